// File: rtl/mux21_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux21_rr_arbiter
//
// Round-robin arbiter for two requesters (A and B) that share one W-bit
// downstream path through a 2:1 selector. The arbiter owns the selector
// control, hands out one-hot grants and registers the selected data onto Y
// together with a valid flag.
//
// Under contention the current owner yields after MAX_HOLD consecutive
// granted cycles. A lone requester keeps the path for as long as it asks.
//
// Parameters:
//   W         data width of A, B and Y
//   MAX_HOLD  consecutive granted cycles allowed while the other side is
//             also requesting (must be >= 1)
//
// Ports:
//   CLK    in   1  rising-edge clock
//   RST    in   1  asynchronous, active-high reset
//   REQ_A  in   1  level request from source A
//   REQ_B  in   1  level request from source B
//   A      in   W  data from source A
//   B      in   W  data from source B
//   GNT_A  out  1  registered grant to A
//   GNT_B  out  1  registered grant to B
//   S      out  1  registered mux select, 0 = A, 1 = B
//   Y      out  W  registered selected data
//   YV     out  1  Y valid
// ---------------------------------------------------------------------------
module mux21_rr_arbiter #(
   parameter int W        = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         REQ_A,
   input  logic         REQ_B,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         GNT_A,
   output logic         GNT_B,
   output logic         S,
   output logic [W-1:0] Y,
   output logic         YV
);

   // Hold counter must be able to represent MAX_HOLD itself.
   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   // Encoding of the "last owner" flag.
   localparam logic SIDE_A = 1'b0;
   localparam logic SIDE_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q,  hold_d;
   logic                last_q,  last_d;
   logic                gnt_a_q, gnt_a_d;
   logic                gnt_b_q, gnt_b_d;
   logic                s_q,     s_d;
   logic [W-1:0]        y_q,     y_d;
   logic                yv_q,    yv_d;

   logic                hold_full;

   assign hold_full = (hold_q == HOLD_MAX);

   // ------------------------------------------------------------------------
   // Next-state arbitration
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (REQ_A && REQ_B) begin
               // Tie: favour the side that did not own the path last.
               state_d = (last_q == SIDE_B) ? OWN_A : OWN_B;
            end else if (REQ_A) begin
               state_d = OWN_A;
            end else if (REQ_B) begin
               state_d = OWN_B;
            end
         end
         OWN_A: begin
            if (!REQ_A) begin
               // Release hands over directly when B is waiting, no idle gap.
               state_d = REQ_B ? OWN_B : IDLE;
            end else if (REQ_B && hold_full) begin
               state_d = OWN_B;
            end
         end
         OWN_B: begin
            if (!REQ_B) begin
               state_d = REQ_A ? OWN_A : IDLE;
            end else if (REQ_A && hold_full) begin
               state_d = OWN_A;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Hold counter, last-owner flag and registered decodes of the next state
   // ------------------------------------------------------------------------
   always_comb begin
      hold_d = hold_q;
      last_d = last_q;

      if (state_d == IDLE) begin
         hold_d = '0;
      end else if (state_d != state_q) begin
         // Entering an OWN state (from IDLE or a direct switch) counts as
         // the first granted cycle.
         hold_d = HOLD_ONE;
         last_d = (state_d == OWN_B) ? SIDE_B : SIDE_A;
      end else if (!hold_full) begin
         hold_d = hold_q + HOLD_ONE;
      end

      gnt_a_d = (state_d == OWN_A);
      gnt_b_d = (state_d == OWN_B);

      // In IDLE the select is left where it was so the mux does not toggle
      // needlessly.
      s_d = s_q;
      if (state_d == OWN_A) begin
         s_d = 1'b0;
      end else if (state_d == OWN_B) begin
         s_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath: capture whatever the selector passes during a granted cycle.
   // Uses the select that was in force during that cycle, so Y lags GNT by
   // one cycle and a direct switch still delivers the old owner's last word.
   // ------------------------------------------------------------------------
   always_comb begin
      y_d  = y_q;
      yv_d = 1'b0;
      if (state_q != IDLE) begin
         y_d  = s_q ? B : A;
         yv_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         hold_q  <= '0;
         last_q  <= SIDE_B;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         s_q     <= 1'b0;
         y_q     <= '0;
         yv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         s_q     <= s_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
      end
   end

   assign GNT_A = gnt_a_q;
   assign GNT_B = gnt_b_q;
   assign S     = s_q;
   assign Y     = y_q;
   assign YV    = yv_q;

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux21_rr_arbiter
//
// Directed bench for mux21_rr_arbiter. Two instances share clock and reset:
// one with MAX_HOLD=4, W=8 and one with MAX_HOLD=1, W=8. Expected values are
// hand-derived from the arbiter's behaviour and written into the step list.
// ---------------------------------------------------------------------------
module tb_mux21_rr_arbiter;

   logic       clk;
   logic       rst;

   logic       ra4, rb4;
   logic [7:0] a4,  b4;
   logic       ga4, gb4, s4, yv4;
   logic [7:0] y4;

   logic       ra1, rb1;
   logic [7:0] a1,  b1;
   logic       ga1, gb1, s1, yv1;
   logic [7:0] y1;

   int ncmp;
   int nfail;

   mux21_rr_arbiter #(.W(8), .MAX_HOLD(4)) dut4 (
      .CLK   (clk),
      .RST   (rst),
      .REQ_A (ra4),
      .REQ_B (rb4),
      .A     (a4),
      .B     (b4),
      .GNT_A (ga4),
      .GNT_B (gb4),
      .S     (s4),
      .Y     (y4),
      .YV    (yv4)
   );

   mux21_rr_arbiter #(.W(8), .MAX_HOLD(1)) dut1 (
      .CLK   (clk),
      .RST   (rst),
      .REQ_A (ra1),
      .REQ_B (rb1),
      .A     (a1),
      .B     (b1),
      .GNT_A (ga1),
      .GNT_B (gb1),
      .S     (s1),
      .Y     (y1),
      .YV    (yv1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Common checks on the MAX_HOLD=4 instance.
   task automatic chk4(input string tag, input logic ga, input logic gb,
                       input logic s, input logic yv, input logic [7:0] y);
      chk({tag, ".gnt_a"}, ga4, ga);
      chk({tag, ".gnt_b"}, gb4, gb);
      chk({tag, ".s"},     s4,  s);
      chk({tag, ".yv"},    yv4, yv);
      chk({tag, ".y"},     y4,  y);
      chk({tag, ".onehot"}, ga4 & gb4, 1'b0);
   endtask

   initial begin
      ncmp  = 0;
      nfail = 0;
      rst   = 1'b1;
      ra4 = 1'b0; rb4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
      ra1 = 1'b0; rb1 = 1'b0; a1 = 8'h00; b1 = 8'h00;

      // Reset state
      step();
      step();
      chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("reset.dut1.gnt", {ga1, gb1, s1, yv1}, 4'b0000);
      rst = 1'b0;

      // Lone requester A for 10 cycles
      a4 = 8'h5A; b4 = 8'h33; ra4 = 1'b1;
      step();
      chk4("lone.first", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int k = 2; k <= 10; k++) begin
         step();
         chk4($sformatf("lone.c%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
      end

      // Release: grant drops next cycle, YV one cycle later, Y holds
      ra4 = 1'b0;
      step();
      chk4("release.c1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
      step();
      chk4("release.c2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);

      // Tie with LAST=A -> B wins, then contention with MAX_HOLD=4
      a4 = 8'hA5; b4 = 8'hB4; ra4 = 1'b1; rb4 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         logic own_b, prev_b;
         own_b  = (((k - 1) / 4) % 2) == 0;
         prev_b = (((k - 2) / 4) % 2) == 0;
         step();
         if (k == 1) begin
            chk4($sformatf("cont.c%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
         end else begin
            chk4($sformatf("cont.c%0d", k), !own_b, own_b, own_b, 1'b1,
                 prev_b ? 8'hB4 : 8'hA5);
         end
      end

      // Both drop -> IDLE, S keeps 1, Y holds B data
      ra4 = 1'b0; rb4 = 1'b0;
      step();
      chk4("idle.c1", 1'b0, 1'b0, 1'b1, 1'b1, 8'hB4);
      step();
      chk4("idle.c2", 1'b0, 1'b0, 1'b1, 1'b0, 8'hB4);

      // Tie with LAST=B -> A wins; A releases after 2nd grant cycle
      ra4 = 1'b1; rb4 = 1'b1;
      step();
      chk4("early.c1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hB4);
      step();
      chk4("early.c2", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
      ra4 = 1'b0;
      step();
      chk4("early.switch", 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
      step();
      chk4("early.b2", 1'b0, 1'b1, 1'b1, 1'b1, 8'hB4);

      // B releases with A waiting -> direct handover to A
      ra4 = 1'b1; rb4 = 1'b0;
      step();
      chk4("toa.c1", 1'b1, 1'b0, 1'b0, 1'b1, 8'hB4);
      step();
      chk4("toa.c2", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);

      // Asynchronous reset mid-cycle while A owns (LAST=A before reset)
      #3;
      rst = 1'b1;
      #1;
      chk4("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      rb4 = 1'b1;
      #2;
      rst = 1'b0;
      step();
      chk4("rst.rearb", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      // Strict alternation with MAX_HOLD=1
      a1 = 8'h11; b1 = 8'h22; ra1 = 1'b1; rb1 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         logic odd_k, prev_a;
         odd_k  = (k % 2) == 1;
         prev_a = ((k - 1) % 2) == 1;
         step();
         chk($sformatf("alt.c%0d.gnt_a", k), ga1, odd_k);
         chk($sformatf("alt.c%0d.gnt_b", k), gb1, !odd_k);
         chk($sformatf("alt.c%0d.s", k),     s1,  !odd_k);
         chk($sformatf("alt.c%0d.yv", k),    yv1, k >= 2);
         chk($sformatf("alt.c%0d.y", k),     y1,
             (k >= 2) ? (prev_a ? 8'h11 : 8'h22) : 8'h00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/mux21_rr_arbiter.md
Name: mux21_rr_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select of a shared 2:1 selector. It lets sources A and B share one downstream W-bit path.
- It issues one-hot grants and drives the select S.
- It registers the selected data onto Y with a valid flag.
- Under contention, the current owner is forced to yield after MAX_HOLD consecutive granted cycles.

Parameters:
- W, 1, data width of A, B, Y.
- MAX_HOLD, 4, max consecutive granted cycles while the other side is requesting. Must be ≥1; the hold counter is sized internally to hold MAX_HOLD.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- REQ_A  input  1  request from source A, level, held while it wants the path
- REQ_B  input  1  request from source B
- A  input  W  data from source A
- B  input  W  data from source B
- GNT_A  output  1  grant to A, registered
- GNT_B  output  1  grant to B, registered
- S  output  1  select for the shared mux, 0=A, 1=B, registered
- Y  output  W  registered selected data
- YV  output  1  Y valid

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high, on RST.
- Reset values (asserted immediately on RST, regardless of CLK):
  - state=IDLE, GNT_A=0, GNT_B=0, S=0, Y=0, YV=0, hold=0.
  - LAST=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B. Outputs are decoded from registered state:
  - OWN_A: GNT_A=1, S=0.
  - OWN_B: GNT_B=1, S=1.
  - IDLE: no grant, and S keeps its previous value.
  - GNT_A and GNT_B are never 1 together.
- Grant latency: a request sampled at edge t yields a grant visible after edge t. That is 1 cycle from REQ high to GNT high.
- IDLE transitions:
  - Only REQ_A → OWN_A.
  - Only REQ_B → OWN_B.
  - Both → the side not equal to LAST.
  - Neither → stay in IDLE.
- OWN_X transitions (Y is the other side), evaluated each edge:
  - REQ_X=0 and REQ_Y=1 → OWN_Y directly, with no idle gap.
  - REQ_X=0 and REQ_Y=0 → IDLE.
  - REQ_X=1, REQ_Y=1, hold==MAX_HOLD → OWN_Y (forced yield).
  - REQ_X=1 otherwise → stay in OWN_X.
- Hold counter:
  - Loads 1 on entry to any OWN state.
  - Increments each cycle the state stays in OWN.
  - Saturates at MAX_HOLD.
  - With no competing request, the owner keeps the grant indefinitely.
  - Cleared to 0 in IDLE.
- LAST is set to X on every entry to OWN_X.
- The owner releases by dropping its REQ. The grant drops the cycle after REQ is sampled low.
- Datapath:
  - Each edge where the state is OWN, Y <= (S ? B : A) and YV <= 1, using the S value current before that edge.
  - In IDLE, Y holds and YV <= 0.
  - Y/YV therefore lag GNT by one cycle, and Y is the data the granted source presented during its grant cycle.
- Switch cycle: on a direct A→B switch, Y on the edge ending the last A cycle still carries A data, with YV=1 continuously.
- MAX_HOLD=1 gives strict alternation every cycle under contention.
- Reset mid-grant: grants, YV and S clear asynchronously. Re-arbitration starts from IDLE with LAST=B after RST deasserts.

Test Plan:
- Reset abort: OWN_A active, Y=1. Pulse RST mid-cycle → GNT_A, YV, Y and S go to 0 before the next CLK edge. After release with REQ_A=REQ_B=1, GNT_A rises first.
- Lone requester: MAX_HOLD=4, W=8, REQ_A=1 for 10 cycles, REQ_B=0, A=8'h5A → GNT_A high 10 cycles starting 1 cycle after REQ_A. There is no yield. Y=8'h5A and YV=1 from the cycle after GNT_A rises.
- Contention: MAX_HOLD=4, REQ_A=REQ_B=1 continuously from IDLE → GNT_A 4 cycles, GNT_B 4 cycles, repeating. S toggles every 4 cycles with no gap in YV.
- Early release: in OWN_A, REQ_B=1, REQ_A drops after the 2nd grant cycle → GNT_B asserts on the very next cycle. GNT_A and GNT_B are never both high, and YV stays 1.
- Idle and fairness:
  - Both REQs drop → IDLE next cycle, YV=0 one cycle later, Y holds its last value.
  - Then REQ_A=REQ_B=1 with LAST=B → A granted.
  - Repeat with LAST=A → B granted.
- Strict alternation: MAX_HOLD=1, both requesting for 6 cycles → grants A,B,A,B,A,B. Y alternates A/B data lagging by 1 cycle.
